irq_sequencer: RTL and testbench

CPU-side consumer of the synchronized, masked interrupt request `REQI` from the interrupt block. It waits for an instruction boundary, stalls fetch, saves the current PC to the stack, and loads the fixed interrupt vector. On the return-from-interrupt instruction it restores the PC and drives the `RTI` pulse back to the interrupt block, which clears its fixed-interrupt latch.

---
 rtl/irq_sequencer.sv | 126 ++++++++++++
 tb/tb_irq_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: takes the masked interrupt request, waits for an instruction
// boundary, pushes the PC and vectors to the ISR. On RETI it pops the PC back
// and drives a multi-cycle RTI pulse to the interrupt block.
//
// state      | meaning
// S_IDLE     | no interrupt activity
// S_WAIT_BND | request seen, waiting for an instruction boundary
// S_SAVE     | fetch stalled, current PC pushed to the stack
// S_VECT     | fetch stalled, PC loaded with the vector, acknowledge
// S_ISR      | executing the handler, requests ignored (no nesting)
// S_RESTORE  | fetch stalled, stack pop issued
// S_RET      | PC reloaded from the stack, RTI held for RTI_PULSE cycles
module irq_sequencer #(
  parameter int          PC_W      = 16,
  parameter int unsigned VECTOR    = 32'h0000_0010,
  parameter int          RTI_PULSE = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            REQI,
  input  logic            INSTR_DONE,
  input  logic            RETI_EXEC,
  input  logic [PC_W-1:0] PC_IN,
  input  logic [PC_W-1:0] POP_DATA,
  output logic            HOLD,
  output logic            PUSH_EN,
  output logic [PC_W-1:0] PUSH_DATA,
  output logic            POP_EN,
  output logic            PC_LOAD,
  output logic [PC_W-1:0] PC_OUT,
  output logic            INTA,
  output logic            IN_ISR,
  output logic            RTI,
  output logic            SPUR_RTI
);

  localparam logic [PC_W-1:0] L_VEC    = PC_W'(VECTOR);
  localparam logic [3:0]      L_CNT_LD = 4'(RTI_PULSE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BND, S_SAVE, S_VECT, S_ISR, S_RESTORE, S_RET
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_req_q;
  logic [3:0]      r_cnt;
  logic            r_hold;
  logic            r_push_en;
  logic [PC_W-1:0] r_push_data;
  logic            r_pop_en;
  logic            r_pc_load;
  logic            r_vect_sel;
  logic            r_inta;
  logic            r_in_isr;
  logic            r_rti;

  // Next-state decision; every choice is made on the registered request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (r_req_q) w_state_nxt = S_WAIT_BND;
      S_WAIT_BND: begin
        if (!r_req_q)        w_state_nxt = S_IDLE;
        else if (INSTR_DONE) w_state_nxt = S_SAVE;
      end
      S_SAVE:     w_state_nxt = S_VECT;
      S_VECT:     w_state_nxt = S_ISR;
      S_ISR:      if (RETI_EXEC) w_state_nxt = S_RESTORE;
      S_RESTORE:  w_state_nxt = S_RET;
      S_RET:      if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // State, request sync, RTI down-counter and outputs registered from the next state.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_req_q     <= 1'b0;
      r_cnt       <= 4'd0;
      r_hold      <= 1'b0;
      r_push_en   <= 1'b0;
      r_push_data <= '0;
      r_pop_en    <= 1'b0;
      r_pc_load   <= 1'b0;
      r_vect_sel  <= 1'b0;
      r_inta      <= 1'b0;
      r_in_isr    <= 1'b0;
      r_rti       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req_q <= REQI;
      if (r_state == S_RESTORE)
        r_cnt <= L_CNT_LD;
      else if (r_state == S_RET && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      r_hold      <= (w_state_nxt == S_SAVE) || (w_state_nxt == S_VECT) ||
                     (w_state_nxt == S_RESTORE) || (w_state_nxt == S_RET);
      r_push_en   <= (w_state_nxt == S_SAVE);
      r_push_data <= (w_state_nxt == S_SAVE) ? PC_IN : '0;
      r_pop_en    <= (w_state_nxt == S_RESTORE);
      // PC load happens on vector entry and on the first RET cycle only.
      r_pc_load   <= (w_state_nxt == S_VECT) ||
                     (w_state_nxt == S_RET && r_state == S_RESTORE);
      r_vect_sel  <= (w_state_nxt == S_VECT);
      r_inta      <= (w_state_nxt == S_VECT);
      r_in_isr    <= (w_state_nxt == S_ISR) || (w_state_nxt == S_RESTORE);
      r_rti       <= (w_state_nxt == S_RET);
    end
  end

  // Stack read data only arrives in the first RET cycle, so the return PC is
  // muxed straight through rather than registered.
  assign PC_OUT    = r_pc_load ? (r_vect_sel ? L_VEC : POP_DATA) : '0;
  assign SPUR_RTI  = RESET & RETI_EXEC & (r_state != S_ISR);
  assign HOLD      = r_hold;
  assign PUSH_EN   = r_push_en;
  assign PUSH_DATA = r_push_data;
  assign POP_EN    = r_pop_en;
  assign PC_LOAD   = r_pc_load;
  assign INTA      = r_inta;
  assign IN_ISR    = r_in_isr;
  assign RTI       = r_rti;

endmodule

// File: tb/tb_irq_sequencer.sv
// Testbench for irq_sequencer: two instances (RTI_PULSE 2 and 3) share the
// stimulus; a cycle-timeline reference model checks both every cycle.
module tb_irq_sequencer;

  logic        clk;
  logic        rst_b;
  logic        reqi;
  logic        idone;
  logic        reti;
  logic [15:0] pc_in;
  logic [15:0] pop_data;

  logic        hold1, push1, pop1, pcl1, inta1, isr1, rti1, spur1;
  logic [15:0] pushd1, pco1;
  logic        hold2, push2, pop2, pcl2, inta2, isr2, rti2, spur2;
  logic [15:0] pushd2, pco2;

  logic [39:0] out_v [2];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] F_HOLD = 8'h80, F_PUSH = 8'h40, F_POP = 8'h20, F_PCL = 8'h10,
                         F_INTA = 8'h08, F_ISR  = 8'h04, F_RTI = 8'h02, F_SPUR = 8'h01;

  irq_sequencer #(.PC_W(16), .VECTOR(32'h10), .RTI_PULSE(2)) dut1 (
    .CLK(clk), .RESET(rst_b), .REQI(reqi), .INSTR_DONE(idone), .RETI_EXEC(reti),
    .PC_IN(pc_in), .POP_DATA(pop_data), .HOLD(hold1), .PUSH_EN(push1), .PUSH_DATA(pushd1),
    .POP_EN(pop1), .PC_LOAD(pcl1), .PC_OUT(pco1), .INTA(inta1), .IN_ISR(isr1),
    .RTI(rti1), .SPUR_RTI(spur1));

  irq_sequencer #(.PC_W(16), .VECTOR(32'h10), .RTI_PULSE(3)) dut2 (
    .CLK(clk), .RESET(rst_b), .REQI(reqi), .INSTR_DONE(idone), .RETI_EXEC(reti),
    .PC_IN(pc_in), .POP_DATA(pop_data), .HOLD(hold2), .PUSH_EN(push2), .PUSH_DATA(pushd2),
    .POP_EN(pop2), .PC_LOAD(pcl2), .PC_OUT(pco2), .INTA(inta2), .IN_ISR(isr2),
    .RTI(rti2), .SPUR_RTI(spur2));

  assign out_v[0] = {hold1, push1, pop1, pcl1, inta1, isr1, rti1, spur1, pco1, pushd1};
  assign out_v[1] = {hold2, push2, pop2, pcl2, inta2, isr2, rti2, spur2, pco2, pushd2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: absolute cycle timeline ----------------
  // An accepted boundary at cycle k puts the push at k+1, the vector at k+2
  // and the handler from k+3; a RETI at cycle r puts the pop at r+1, RTI over
  // r+2 .. r+1+P and idle again at r+2+P.
  logic        m_busy [2];
  logic        m_wait [2];
  int          m_k    [2];
  int          m_r    [2];
  logic [15:0] m_pc   [2];
  logic        m_reqq;
  int          cyc = 0;
  bit          m_en = 0;

  function automatic int pulse_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic logic [39:0] exp_out(input int i);
    logic [7:0]  f;
    logic [15:0] pco, pd;
    logic        in_isr_state;
    int          d;
    f = 8'h00; pco = 16'h0; pd = 16'h0; in_isr_state = 1'b0;
    if (m_busy[i] === 1'b1) begin
      if (m_r[i] < 0) begin
        d = cyc - m_k[i];
        if (d == 1) begin f = F_HOLD | F_PUSH; pd = m_pc[i]; end
        else if (d == 2) begin f = F_HOLD | F_PCL | F_INTA; pco = 16'h0010; end
        else begin f = F_ISR; in_isr_state = 1'b1; end
      end else begin
        d = cyc - m_r[i];
        if (d == 1) f = F_HOLD | F_POP | F_ISR;
        else begin
          f = F_HOLD | F_RTI;
          if (d == 2) begin f = f | F_PCL; pco = pop_data; end
        end
      end
    end
    if (rst_b && reti && !in_isr_state) f = f | F_SPUR;
    return {f, pco, pd};
  endfunction

  always @(negedge clk) begin
    if (m_en) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("model dut%0d cyc %0d", i + 1, cyc), out_v[i], exp_out(i));
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_b) begin
        m_busy[i] = 1'b0;
        m_wait[i] = 1'b0;
      end else if (m_busy[i] === 1'b1) begin
        if (m_r[i] < 0) begin
          if (cyc - m_k[i] >= 3 && reti) m_r[i] = cyc;
        end else if (cyc == m_r[i] + 1 + pulse_of(i)) begin
          m_busy[i] = 1'b0;
        end
      end else if (m_wait[i] === 1'b1) begin
        if (!m_reqq) m_wait[i] = 1'b0;
        else if (idone) begin
          m_wait[i] = 1'b0;
          m_busy[i] = 1'b1;
          m_k[i]    = cyc;
          m_r[i]    = -1;
          m_pc[i]   = pc_in;
        end
      end else if (m_reqq === 1'b1) begin
        m_wait[i] = 1'b1;
      end
    end
    m_reqq = rst_b ? reqi : 1'b0;
    if (!rst_b) m_en = 1;
    cyc++;
  end

  // ---------------- directed vector table (RTI_PULSE = 2 instance) ----------------
  typedef struct {
    logic        rst_b, reqi, idone, reti;
    logic [7:0]  flags;
    logic [15:0] pc_out, push_data;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic q, input logic d, input logic e,
                              input logic [7:0] f, input logic [15:0] pco, input logic [15:0] pd);
    vec_t v;
    v.rst_b = r; v.reqi = q; v.idone = d; v.reti = e;
    v.flags = f; v.pc_out = pco; v.push_data = pd;
    return v;
  endfunction

  vec_t tbl [27];

  initial begin
    int   n;
    int   n_hi;
    logic nd;

    // entry: REQI rises at row 0, boundary 4 cycles later
    tbl[0]  = mk(1, 1, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[1]  = mk(1, 1, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[2]  = mk(1, 1, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[3]  = mk(1, 1, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[4]  = mk(1, 1, 1, 0, 8'h00, 16'h0, 16'h0);
    tbl[5]  = mk(1, 1, 0, 0, F_HOLD | F_PUSH, 16'h0, 16'h1234);
    tbl[6]  = mk(1, 1, 0, 0, F_HOLD | F_PCL | F_INTA, 16'h0010, 16'h0);
    // handler; REQI toggling must not nest
    tbl[7]  = mk(1, 1, 0, 0, F_ISR, 16'h0, 16'h0);
    tbl[8]  = mk(1, 0, 1, 0, F_ISR, 16'h0, 16'h0);
    tbl[9]  = mk(1, 1, 1, 0, F_ISR, 16'h0, 16'h0);
    tbl[10] = mk(1, 0, 0, 1, F_ISR, 16'h0, 16'h0);
    // return
    tbl[11] = mk(1, 0, 0, 0, F_HOLD | F_POP | F_ISR, 16'h0, 16'h0);
    tbl[12] = mk(1, 0, 0, 0, F_HOLD | F_PCL | F_RTI, 16'h1235, 16'h0);
    tbl[13] = mk(1, 0, 0, 0, F_HOLD | F_RTI, 16'h0, 16'h0);
    tbl[14] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    // spurious RETI in idle
    tbl[15] = mk(1, 0, 0, 1, F_SPUR, 16'h0, 16'h0);
    tbl[16] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    // withdrawn request
    tbl[17] = mk(1, 1, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[18] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[19] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[20] = mk(1, 0, 1, 0, 8'h00, 16'h0, 16'h0);
    tbl[21] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    // boundary in the same cycle the registered request falls
    tbl[22] = mk(1, 1, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[23] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[24] = mk(1, 0, 1, 0, 8'h00, 16'h0, 16'h0);
    tbl[25] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    tbl[26] = mk(1, 0, 0, 0, 8'h00, 16'h0, 16'h0);

    rst_b = 1'b0; reqi = 1'b0; idone = 1'b0; reti = 1'b0;
    pc_in = 16'h1234; pop_data = 16'h1235;

    // reset state
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("reset dut1", out_v[0], 40'h0);
    chk("reset dut2", out_v[1], 40'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 27; i++) begin
      rst_b = tbl[i].rst_b; reqi = tbl[i].reqi; idone = tbl[i].idone; reti = tbl[i].reti;
      @(negedge clk);
      chk($sformatf("vec%0d", i), out_v[0], {tbl[i].flags, tbl[i].pc_out, tbl[i].push_data});
      @(posedge clk); #1;
    end

    // reset held for 3 cycles starting in VECT
    pc_in = 16'h4444; reqi = 1'b1; idone = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (push1) break;
      @(posedge clk); #1;
    end
    chk("rst-vect reach save", 40'(n < 20), 40'd1);
    @(posedge clk); #1;
    rst_b = 1'b0; reqi = 1'b0; idone = 1'b0;
    @(negedge clk);
    chk("rst-vect in vect", {32'h0, inta1, pcl1, hold1, 5'h0}, {32'h0, 3'b111, 5'h0});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rst-vect held %0d", i), out_v[0], 40'h0);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst-vect after %0d", i), out_v[0], 40'h0);
      @(posedge clk); #1;
    end

    // back-to-back on the RTI_PULSE = 3 instance
    pc_in = 16'h2222; pop_data = 16'h3333; reqi = 1'b1; idone = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (push2) break;
      @(posedge clk); #1;
    end
    chk("b2b push1", {23'h0, push2, pushd2}, {23'h0, 1'b1, 16'h2222});
    @(posedge clk); #1;
    idone = 1'b0;
    @(negedge clk);
    chk("b2b vect1", {22'h0, pcl2, inta2, pco2}, {22'h0, 2'b11, 16'h0010});
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b isr1", {39'h0, isr2}, 40'h1);
    @(posedge clk); #1;
    reti = 1'b1;
    @(posedge clk); #1;
    reti = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rti2) break;
      @(posedge clk); #1;
    end
    n_hi = 0;
    while (rti2 && n_hi < 10) begin
      n_hi++;
      @(posedge clk); #1;
      reqi = 1'b0;
      @(negedge clk);
    end
    chk("b2b rti width", 40'(n_hi), 40'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reqi = 1'b1; idone = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (push2) break;
      @(posedge clk); #1;
    end
    chk("b2b push2", {23'h0, push2, pushd2}, {23'h0, 1'b1, 16'h2222});
    @(posedge clk); #1;
    idone = 1'b0; reqi = 1'b0;
    @(negedge clk);
    chk("b2b vect2", {22'h0, pcl2, inta2, pco2}, {22'h0, 2'b11, 16'h0010});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reti = 1'b1;
    @(posedge clk); #1;
    reti = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_b = ($urandom_range(99) != 0);
      if ($urandom_range(7) == 0) reqi = ~reqi;
      nd = ($urandom_range(2) == 0);
      if (!nd && !idone) pc_in = 16'($urandom);
      idone = nd;
      reti = ($urandom_range(11) == 0);
      pop_data = 16'($urandom);
      @(posedge clk); #1;
    end
    rst_b = 1'b1; reqi = 1'b0; idone = 1'b0; reti = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
